// File: rtl/mult_sched_pkg.sv
// Shared widths and the round-robin pick helper for the multiplier scheduler.
package mult_sched_pkg;

    localparam int A_W     = 28;
    localparam int B_W     = 32;
    localparam int P_W     = 60;
    localparam int MAX_REQ = 8;
    localparam int PTR_W   = 3;

    // First eligible index at or above ptr (wrapping at nreq) wins; result is one-hot or zero.
    function automatic logic [MAX_REQ-1:0] rr_pick(input logic [MAX_REQ-1:0] eligible,
                                                   input logic [PTR_W-1:0]   ptr,
                                                   input int                 nreq);
        logic [MAX_REQ-1:0] grant;
        logic               found;
        int                 idx;
        grant = '0;
        found = 1'b0;
        for (int k = 0; k < MAX_REQ; k++) begin
            idx = (int'(ptr) + k) % nreq;
            if ((k < nreq) && !found && eligible[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
        return grant;
    endfunction

endpackage

// File: rtl/mult_sched_if.sv
// Requester and response bundle of the shared-multiplier scheduler.
interface mult_sched_if #(parameter int NREQ = 4);
    import mult_sched_pkg::*;

    localparam int IDW = $clog2(NREQ);

    logic [NREQ-1:0]     req_valid;
    logic [NREQ-1:0]     req_ready;
    logic [NREQ*A_W-1:0] req_a;
    logic [NREQ*B_W-1:0] req_b;
    logic [NREQ-1:0]     req_mask;
    logic                rsp_valid;
    logic [IDW-1:0]      rsp_id;
    logic [P_W-1:0]      rsp_data;
    logic                busy;

    modport master (output req_valid, req_a, req_b, req_mask,
                    input  req_ready, rsp_valid, rsp_id, rsp_data, busy);

    modport slave  (input  req_valid, req_a, req_b, req_mask,
                    output req_ready, rsp_valid, rsp_id, rsp_data, busy);

endinterface

// File: rtl/mult_sched_mult_pipe.sv
// LAT-stage signed A_W x B_W multiplier; each stage only loads when its enable is set,
// so the last stage holds the most recent valid product.
module mult_pipe
    import mult_sched_pkg::*;
#(
    parameter int LAT = 1
) (
    input  logic                  pclk,
    input  logic                  reset,
    input  logic [LAT-1:0]        en,
    input  logic signed [A_W-1:0] a,
    input  logic signed [B_W-1:0] b,
    output logic signed [P_W-1:0] p
);

    logic signed [P_W-1:0] prod_s;
    logic signed [P_W-1:0] stage_r [LAT];

    // Full-precision product of sign-extended operands.
    always_comb begin
        prod_s = $signed({{(P_W-A_W){a[A_W-1]}}, a}) * $signed({{(P_W-B_W){b[B_W-1]}}, b});
    end

    // Enabled pipeline stages; a bubble leaves the stage holding its previous value.
    always_ff @(posedge pclk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < LAT; k++) begin
                stage_r[k] <= '0;
            end
        end else begin
            if (en[0]) begin
                stage_r[0] <= prod_s;
            end
            for (int k = 1; k < LAT; k++) begin
                if (en[k]) begin
                    stage_r[k] <= stage_r[k-1];
                end
            end
        end
    end

    assign p = stage_r[LAT-1];

endmodule

// File: rtl/mult_sched.sv
// Round-robin scheduler sharing one signed multiplier between NREQ requesters;
// products come back tagged with the requester index LAT cycles after the accept.
module mult_sched
    import mult_sched_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int LAT  = 1
) (
    input  logic        pclk,
    input  logic        reset,
    mult_sched_if.slave bus
);

    localparam int IDW = $clog2(NREQ);

    logic [NREQ-1:0]       elig_s;
    logic [NREQ-1:0]       grant_s;
    logic [MAX_REQ-1:0]    pick_s;
    logic                  unused_pick_s;
    logic                  accept_s;
    logic [IDW-1:0]        g_idx_s;
    logic [IDW-1:0]        ptr_next_s;
    logic [IDW-1:0]        rr_ptr_r;
    logic signed [A_W-1:0] a_sel_s;
    logic signed [B_W-1:0] b_sel_s;
    logic signed [P_W-1:0] prod_s;
    logic [LAT-1:0]        stage_en_s;
    logic                  busy_next_s;
    logic                  busy_r;
    logic                  v_r  [LAT];
    logic [IDW-1:0]        id_r [LAT];

    // Arbitration, operand selection and next-state terms.
    always_comb begin
        elig_s   = bus.req_valid & ~bus.req_mask;
        pick_s   = rr_pick(MAX_REQ'(elig_s), PTR_W'(rr_ptr_r), NREQ);
        grant_s  = pick_s[NREQ-1:0];
        accept_s = |grant_s;
        g_idx_s  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant_s[i]) begin
                g_idx_s = IDW'(i);
            end else begin
                g_idx_s = g_idx_s;
            end
        end
        if (g_idx_s == IDW'(NREQ-1)) begin
            ptr_next_s = '0;
        end else begin
            ptr_next_s = g_idx_s + IDW'(1);
        end
        a_sel_s = bus.req_a[g_idx_s*A_W +: A_W];
        b_sel_s = bus.req_b[g_idx_s*B_W +: B_W];
        // Stage k of the multiplier advances when the tag in front of it is valid.
        stage_en_s[0] = accept_s;
        for (int k = 1; k < LAT; k++) begin
            stage_en_s[k] = v_r[k-1];
        end
        busy_next_s = accept_s;
        for (int k = 0; k < LAT-1; k++) begin
            busy_next_s = busy_next_s | v_r[k];
        end
    end

    assign unused_pick_s = ^pick_s;

    mult_pipe #(.LAT(LAT)) u_mult (
        .pclk  (pclk),
        .reset (reset),
        .en    (stage_en_s),
        .a     (a_sel_s),
        .b     (b_sel_s),
        .p     (prod_s)
    );

    // Round-robin pointer, tag/valid pipeline and busy flag.
    always_ff @(posedge pclk or posedge reset) begin
        if (reset) begin
            rr_ptr_r <= '0;
            busy_r   <= 1'b0;
            for (int k = 0; k < LAT; k++) begin
                v_r[k]  <= 1'b0;
                id_r[k] <= '0;
            end
        end else begin
            if (accept_s) begin
                rr_ptr_r <= ptr_next_s;
            end
            busy_r  <= busy_next_s;
            v_r[0]  <= accept_s;
            id_r[0] <= g_idx_s;
            for (int k = 1; k < LAT; k++) begin
                v_r[k]  <= v_r[k-1];
                id_r[k] <= id_r[k-1];
            end
        end
    end

    assign bus.req_ready = reset ? '0 : grant_s;
    assign bus.rsp_valid = v_r[LAT-1];
    assign bus.rsp_id    = id_r[LAT-1];
    assign bus.rsp_data  = prod_s;
    assign bus.busy      = busy_r;

endmodule

// File: tb/tb_mult_sched.sv
// Self-checking bench for mult_sched: queue-based reference model plus directed literal checks.
module tb_mult_sched;
    import mult_sched_pkg::*;

    localparam int NREQ = 4;
    localparam int LAT  = 1;

    typedef logic signed [63:0] val_t;
    typedef struct {
        int     due;
        int     id;
        longint prod;
    } exp_t;

    logic pclk  = 1'b0;
    logic reset = 1'b1;

    mult_sched_if #(.NREQ(NREQ)) bus ();

    mult_sched #(.NREQ(NREQ), .LAT(LAT)) dut (
        .pclk  (pclk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 pclk = ~pclk;

    int     n_vec = 0;
    int     n_err = 0;
    int     cyc   = 0;
    exp_t   exp_q[$];
    exp_t   e;
    int     m_ptr = 0;
    longint last_data = 0;
    int     wait_cnt [NREQ];
    int     g;
    logic [NREQ-1:0] elig;
    logic [NREQ-1:0] exp_ready;

    always @(posedge pclk) cyc <= cyc + 1;

    task automatic chk(input string name, input val_t act, input val_t expv);
        n_vec++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s @cycle %0d: got %0d, expected %0d", name, cyc, act, expv);
        end
    endtask

    function automatic longint op_a(input int i);
        logic signed [A_W-1:0] v;
        v = bus.req_a[A_W*i +: A_W];
        return longint'(v);
    endfunction

    function automatic longint op_b(input int i);
        logic signed [B_W-1:0] v;
        v = bus.req_b[B_W*i +: B_W];
        return longint'(v);
    endfunction

    // Reference model: accepted pairs wait in a queue until their due cycle.
    always @(negedge pclk) begin
        if (reset) begin
            chk("rst_ready", val_t'(bus.req_ready), 64'sd0);
            chk("rst_valid", val_t'(bus.rsp_valid), 64'sd0);
            chk("rst_id",    val_t'(bus.rsp_id),    64'sd0);
            chk("rst_data",  val_t'($signed(bus.rsp_data)), 64'sd0);
            chk("rst_busy",  val_t'(bus.busy),      64'sd0);
            exp_q.delete();
            m_ptr     = 0;
            last_data = 0;
            for (int i = 0; i < NREQ; i++) wait_cnt[i] = 0;
        end else begin
            chk("busy", val_t'(bus.busy), val_t'(exp_q.size() > 0));
            if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
                e = exp_q.pop_front();
                chk("rsp_valid", val_t'(bus.rsp_valid), 64'sd1);
                chk("rsp_id",    val_t'(bus.rsp_id),    val_t'(e.id));
                chk("rsp_data",  val_t'($signed(bus.rsp_data)), val_t'(e.prod));
                last_data = e.prod;
            end else begin
                chk("rsp_idle",  val_t'(bus.rsp_valid), 64'sd0);
                chk("rsp_hold",  val_t'($signed(bus.rsp_data)), val_t'(last_data));
            end
            elig = bus.req_valid & ~bus.req_mask;
            g = -1;
            for (int k = 0; k < NREQ; k++) begin
                if (g < 0 && elig[(m_ptr + k) % NREQ]) g = (m_ptr + k) % NREQ;
            end
            exp_ready = '0;
            if (g >= 0) exp_ready[g] = 1'b1;
            chk("req_ready", val_t'(bus.req_ready), val_t'(exp_ready));
            if (g >= 0) begin
                exp_q.push_back('{due: cyc + LAT, id: g, prod: op_a(g) * op_b(g)});
                m_ptr = (g + 1) % NREQ;
            end
            for (int i = 0; i < NREQ; i++) begin
                if (elig[i] && i != g) begin
                    wait_cnt[i]++;
                    if (wait_cnt[i] >= NREQ) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL starvation @cycle %0d: req %0d waited %0d, limit %0d",
                                 cyc, i, wait_cnt[i], NREQ - 1);
                    end
                end else begin
                    wait_cnt[i] = 0;
                end
            end
        end
    end

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    task automatic set_op(input int i, input longint a, input longint b);
        bus.req_a[A_W*i +: A_W] = A_W'(a);
        bus.req_b[B_W*i +: B_W] = B_W'(b);
    endtask

    function automatic longint rnd_a();
        case ($urandom_range(7))
            0:       return -64'sd134217728;
            1:       return 64'sd134217727;
            2:       return 64'sd0;
            3:       return -64'sd1;
            default: return longint'($urandom);
        endcase
    endfunction

    function automatic longint rnd_b();
        case ($urandom_range(7))
            0:       return -64'sd2147483648;
            1:       return 64'sd2147483647;
            2:       return 64'sd0;
            3:       return -64'sd1;
            default: return longint'($urandom);
        endcase
    endfunction

    task automatic pulse_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    int mask_order [6] = '{1, 4, 8, 1, 4, 8};

    initial begin
        bus.req_valid = '0;
        bus.req_mask  = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        repeat (3) @(posedge pclk);
        #1;
        reset = 1'b0;

        // Single request: 3 * -5 from requester 2.
        bus.req_valid = 4'b0100;
        set_op(2, 3, -5);
        @(negedge pclk);
        chk("t1_ready", val_t'(bus.req_ready), 64'sd4);
        tick();
        bus.req_valid = '0;
        @(negedge pclk);
        chk("t1_valid", val_t'(bus.rsp_valid), 64'sd1);
        chk("t1_id",    val_t'(bus.rsp_id),    64'sd2);
        chk("t1_data",  val_t'($signed(bus.rsp_data)), -64'sd15);
        chk("t1_busy",  val_t'(bus.busy),      64'sd1);
        tick();
        @(negedge pclk);
        chk("t1_busy_off", val_t'(bus.busy), 64'sd0);
        chk("t1_hold", val_t'($signed(bus.rsp_data)), -64'sd15);
        tick();

        // All requesters valid from a fresh pointer.
        pulse_reset();
        bus.req_valid = 4'b1111;
        for (int i = 0; i < NREQ; i++) set_op(i, rnd_a(), rnd_b());
        for (int k = 0; k < 8; k++) begin
            @(negedge pclk);
            chk("rr_order", val_t'(bus.req_ready), val_t'(1 << (k % 4)));
            if (k > 0) chk("rr_rsp_id", val_t'(bus.rsp_id), val_t'((k - 1) % 4));
            tick();
        end

        // Requester 1 masked out.
        bus.req_mask = 4'b0010;
        for (int k = 0; k < 6; k++) begin
            @(negedge pclk);
            chk("mask_order", val_t'(bus.req_ready), val_t'(mask_order[k]));
            tick();
        end
        bus.req_mask  = '0;
        bus.req_valid = '0;
        tick();

        // Operand extremes.
        bus.req_valid = 4'b0001;
        set_op(0, -64'sd134217728, -64'sd2147483648);
        tick();
        set_op(0, 64'sd134217727, -64'sd2147483648);
        @(negedge pclk);
        chk("ext_min_min", val_t'($signed(bus.rsp_data)), 64'sd288230376151711744);
        tick();
        bus.req_valid = '0;
        @(negedge pclk);
        chk("ext_max_min", val_t'($signed(bus.rsp_data)), -64'sd288230374004228096);
        tick();

        // Reset between accept and response.
        bus.req_valid = 4'b0100;
        set_op(2, 7, 9);
        tick();
        reset = 1'b1;
        bus.req_valid = '0;
        @(negedge pclk);
        chk("rst_drop", val_t'(bus.rsp_valid), 64'sd0);
        tick();
        reset = 1'b0;
        bus.req_valid = 4'b1010;
        @(negedge pclk);
        chk("rst_first", val_t'(bus.req_ready), 64'sd2);
        tick();
        bus.req_valid = '0;
        @(negedge pclk);
        chk("rst_first_id", val_t'(bus.rsp_id), 64'sd1);
        tick();

        // Random valid/mask/operand traffic with occasional resets.
        for (int n = 0; n < 10000; n++) begin
            bus.req_valid = NREQ'($urandom);
            if ($urandom_range(15) == 0) bus.req_mask = NREQ'($urandom);
            for (int i = 0; i < NREQ; i++) set_op(i, rnd_a(), rnd_b());
            reset = ($urandom_range(1999) == 0);
            tick();
        end
        reset = 1'b0;
        bus.req_valid = '0;
        repeat (LAT + 3) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
